// File: rtl/write_back_buffer.sv
// Write-back buffer: holds one dirty 128-bit cache line and drains it as a
// 4-beat, 32-bit INCR AXI write burst, with a line-address conflict check.
module write_back_buffer #(
    parameter logic [3:0]  AXI_ID     = 4'd1,
    parameter int unsigned LINE_BEATS = 4
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         i_wb_req,
    input  logic [31:0]  i_wb_addr,
    input  logic [127:0] i_wb_data,
    output logic         o_wb_rdy,
    output logic         o_wb_done,

    input  logic [31:0]  i_chk_addr,
    output logic         o_chk_hit,

    output logic         o_awvalid,
    input  logic         i_awready,
    output logic [31:0]  o_awaddr,
    output logic [3:0]   o_awid,
    output logic [7:0]   o_awlen,
    output logic [2:0]   o_awsize,
    output logic [1:0]   o_awburst,

    output logic         o_wvalid,
    input  logic         i_wready,
    output logic [31:0]  o_wdata,
    output logic [3:0]   o_wstrb,
    output logic         o_wlast,

    input  logic         i_bvalid,
    output logic         o_bready
);

    localparam logic [1:0] LAST_BEAT = 2'(LINE_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [27:0]    line_addr_q, line_addr_d;
    logic [127:0]   line_data_q, line_data_d;
    logic           done_q, done_d;
    logic [31:0]    beat_data_s;
    logic           unused_addr_lsbs_s;

    // Offset bits inside a line are irrelevant to both the burst and the check.
    assign unused_addr_lsbs_s = ^{i_wb_addr[3:0], i_chk_addr[3:0]};

    // State, beat counter, captured line and completion pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            line_addr_q <= 28'd0;
            line_data_q <= 128'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_addr_q <= line_addr_d;
            line_data_q <= line_data_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic for the IDLE -> AW -> W -> B sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_addr_d = line_addr_q;
        line_data_d = line_data_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_wb_req) begin
                    state_d     = ST_AW;
                    cnt_d       = 2'd0;
                    line_addr_d = i_wb_addr[31:4];
                    line_data_d = i_wb_data;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_AW: begin
                if (i_awready) begin
                    state_d = ST_W;
                    cnt_d   = 2'd0;
                end else begin
                    state_d = ST_AW;
                end
            end
            ST_W: begin
                if (i_wready) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_B;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_B: begin
                if (i_bvalid) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_B;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Beat select: word 0 leaves first so a shift-in receiver rebuilds the line in order.
    always_comb begin
        beat_data_s = 32'd0;
        case (cnt_q)
            2'd0:    beat_data_s = line_data_q[31:0];
            2'd1:    beat_data_s = line_data_q[63:32];
            2'd2:    beat_data_s = line_data_q[95:64];
            2'd3:    beat_data_s = line_data_q[127:96];
            default: beat_data_s = 32'd0;
        endcase
    end

    assign o_wb_rdy  = (state_q == ST_IDLE);
    assign o_wb_done = done_q;

    assign o_awvalid = (state_q == ST_AW);
    assign o_awaddr  = {line_addr_q, 4'b0000};
    assign o_awid    = AXI_ID;
    assign o_awlen   = 8'd3;
    assign o_awsize  = 3'b010;
    assign o_awburst = 2'b01;

    assign o_wvalid  = (state_q == ST_W);
    assign o_wdata   = beat_data_s;
    assign o_wstrb   = 4'hF;
    assign o_wlast   = (state_q == ST_W) && (cnt_q == LAST_BEAT);

    assign o_bready  = (state_q == ST_B);

    assign o_chk_hit = (state_q != ST_IDLE) && (i_chk_addr[31:4] == line_addr_q);

endmodule

// File: tb/tb_write_back_buffer.sv
// Self-checking bench for write_back_buffer: directed scenarios plus random
// traffic, all checked against a transaction-level model of the buffer.
module tb_write_back_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_wb_req;
    logic [31:0]  i_wb_addr;
    logic [127:0] i_wb_data;
    logic         o_wb_rdy;
    logic         o_wb_done;
    logic [31:0]  i_chk_addr;
    logic         o_chk_hit;
    logic         o_awvalid;
    logic         i_awready;
    logic [31:0]  o_awaddr;
    logic [3:0]   o_awid;
    logic [7:0]   o_awlen;
    logic [2:0]   o_awsize;
    logic [1:0]   o_awburst;
    logic         o_wvalid;
    logic         i_wready;
    logic [31:0]  o_wdata;
    logic [3:0]   o_wstrb;
    logic         o_wlast;
    logic         i_bvalid;
    logic         o_bready;

    always #5 clk = ~clk;

    write_back_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .i_wb_req   (i_wb_req),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .o_wb_rdy   (o_wb_rdy),
        .o_wb_done  (o_wb_done),
        .i_chk_addr (i_chk_addr),
        .o_chk_hit  (o_chk_hit),
        .o_awvalid  (o_awvalid),
        .i_awready  (i_awready),
        .o_awaddr   (o_awaddr),
        .o_awid     (o_awid),
        .o_awlen    (o_awlen),
        .o_awsize   (o_awsize),
        .o_awburst  (o_awburst),
        .o_wvalid   (o_wvalid),
        .i_wready   (i_wready),
        .o_wdata    (o_wdata),
        .o_wstrb    (o_wstrb),
        .o_wlast    (o_wlast),
        .i_bvalid   (i_bvalid),
        .o_bready   (o_bready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Transaction-level model: one pending line, progress counted in AXI handshakes.
    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
    } line_t;

    line_t pend_q[$];
    logic  aw_sent_m   = 1'b0;
    int    beats_m     = 0;
    logic  exp_done_m  = 1'b0;

    // Monitor on the falling edge: check current outputs, then apply the coming edge.
    always @(negedge clk) begin
        logic        busy, exp_aw, exp_w, exp_b, exp_hit;
        logic [31:0] cur_addr;
        logic [127:0] cur_data;
        busy     = (pend_q.size() != 0);
        cur_addr = busy ? pend_q[0].addr : 32'd0;
        cur_data = busy ? pend_q[0].data : 128'd0;
        exp_aw   = busy && !aw_sent_m;
        exp_w    = busy && aw_sent_m && (beats_m < 4);
        exp_b    = busy && (beats_m == 4);
        exp_hit  = busy && (i_chk_addr[31:4] == cur_addr[31:4]);

        check_eq("m_wb_rdy",  32'(o_wb_rdy),  32'(!busy));
        check_eq("m_awvalid", 32'(o_awvalid), 32'(exp_aw));
        check_eq("m_wvalid",  32'(o_wvalid),  32'(exp_w));
        check_eq("m_bready",  32'(o_bready),  32'(exp_b));
        check_eq("m_wlast",   32'(o_wlast),   32'(exp_w && (beats_m == 3)));
        check_eq("m_done",    32'(o_wb_done), 32'(exp_done_m));
        check_eq("m_chk_hit", 32'(o_chk_hit), 32'(exp_hit));
        check_eq("m_consts",  {15'd0, o_awid, o_awlen, o_awsize, o_awburst},
                              {15'd0, 4'd1, 8'd3, 3'b010, 2'b01});
        check_eq("m_wstrb",   32'(o_wstrb),   32'hF);
        if (exp_aw) check_eq("m_awaddr", o_awaddr, {cur_addr[31:4], 4'b0000});
        if (exp_w)  check_eq("m_wdata",  o_wdata,  cur_data[beats_m*32 +: 32]);

        exp_done_m = 1'b0;
        if (rst) begin
            pend_q.delete();
            aw_sent_m = 1'b0;
            beats_m   = 0;
        end else if (exp_aw && i_awready) begin
            aw_sent_m = 1'b1;
        end else if (exp_w && i_wready) begin
            beats_m++;
        end else if (exp_b && i_bvalid) begin
            pend_q.delete();
            aw_sent_m  = 1'b0;
            beats_m    = 0;
            exp_done_m = 1'b1;
        end
        if (!rst && !busy && i_wb_req) pend_q.push_back('{i_wb_addr, i_wb_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!o_wb_done && n < budget) begin
            tick();
            n++;
        end
        check_eq("done_seen", 32'(o_wb_done), 32'd1);
    endtask

    logic [31:0]  t1_words [4];
    int           pat [7];
    logic [31:0]  last_addr;

    initial begin
        int n, nb, hs;
        logic [31:0]  prev_wdata;
        logic         prev_wlast;
        logic [127:0] d;

        rst = 1'b1; i_wb_req = 1'b0; i_wb_addr = 32'd0; i_wb_data = 128'd0;
        i_chk_addr = 32'd0; i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0;
        t1_words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        pat      = '{1, 0, 0, 1, 1, 0, 1};
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_rdy",     32'(o_wb_rdy),  32'd1);
        check_eq("rst_awvalid", 32'(o_awvalid), 32'd0);
        check_eq("rst_awaddr",  o_awaddr,       32'd0);

        // Basic burst with all readies high, latency to done.
        i_awready = 1'b1; i_wready = 1'b1; i_bvalid = 1'b1;
        i_wb_req  = 1'b1; i_wb_addr = 32'h1C00_0047;
        i_wb_data = {t1_words[3], t1_words[2], t1_words[1], t1_words[0]};
        tick();
        i_wb_req = 1'b0;
        check_eq("t1_awaddr", o_awaddr, 32'h1C00_0040);
        n = 1; nb = 0;
        while (!o_wb_done && n < 20) begin
            if (o_wvalid && i_wready) begin
                if (nb < 4) check_eq("t1_beat", o_wdata, t1_words[nb]);
                check_eq("t1_wlast", 32'(o_wlast), 32'(nb == 3));
                nb++;
            end
            tick();
            n++;
        end
        check_eq("t1_latency", 32'(n), 32'd7);
        check_eq("t1_nbeats",  32'(nb), 32'd4);
        tick();
        check_eq("t1_done_pulse", 32'(o_wb_done), 32'd0);

        // AW stall for 5 cycles, with conflict checks.
        i_awready = 1'b0;
        i_wb_req = 1'b1; i_wb_addr = 32'h1C00_0040;
        i_wb_data = {$urandom, $urandom, $urandom, $urandom};
        i_chk_addr = 32'h1C00_004C; #1;
        check_eq("t4_hit_accept", 32'(o_chk_hit), 32'd0);
        tick();
        i_wb_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("t2_awvalid", 32'(o_awvalid), 32'd1);
            check_eq("t2_awaddr",  o_awaddr,       32'h1C00_0040);
            check_eq("t2_wvalid",  32'(o_wvalid),  32'd0);
            i_chk_addr = 32'h1C00_004C; #1;
            check_eq("t4_hit_same", 32'(o_chk_hit), 32'd1);
            i_chk_addr = 32'h1C00_0050; #1;
            check_eq("t4_hit_next", 32'(o_chk_hit), 32'd0);
            tick();
        end
        i_awready = 1'b1;
        wait_done(20);
        i_chk_addr = 32'h1C00_004C; #1;
        check_eq("t4_hit_after", 32'(o_chk_hit), 32'd0);

        // W ready pattern 1,0,0,1,1,0,1 yields exactly four beats.
        i_wready = 1'b0;
        i_wb_req = 1'b1; i_wb_addr = $urandom;
        i_wb_data = {$urandom, $urandom, $urandom, $urandom};
        tick();
        i_wb_req = 1'b0;
        tick();
        hs = 0;
        for (int i = 0; i < 7; i++) begin
            i_wready   = pat[i][0];
            prev_wdata = o_wdata;
            prev_wlast = o_wlast;
            if (o_wvalid && i_wready) hs++;
            tick();
            if (pat[i] == 0) begin
                check_eq("t3_stall_wdata", o_wdata,         prev_wdata);
                check_eq("t3_stall_wlast", 32'(o_wlast),    32'(prev_wlast));
            end
        end
        check_eq("t3_handshakes", 32'(hs), 32'd4);
        check_eq("t3_in_b",       32'(o_bready), 32'd1);
        i_wready = 1'b1;
        wait_done(20);

        // Reset in the cycle after the third beat handshake.
        i_wb_req = 1'b1; i_wb_addr = $urandom;
        i_wb_data = {$urandom, $urandom, $urandom, $urandom};
        tick();
        i_wb_req = 1'b0;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t5_rdy",     32'(o_wb_rdy),  32'd1);
        check_eq("t5_valids",  {28'd0, o_awvalid, o_wvalid, o_wlast, o_bready}, 32'd0);
        check_eq("t5_done",    32'(o_wb_done), 32'd0);
        check_eq("t5_wdata",   o_wdata,        32'd0);
        d = {$urandom, $urandom, $urandom, $urandom};
        i_wb_req = 1'b1; i_wb_addr = $urandom; i_wb_data = d;
        tick();
        i_wb_req = 1'b0;
        tick();
        check_eq("t5_restart_w",     o_wdata,      d[31:0]);
        check_eq("t5_restart_wlast", 32'(o_wlast), 32'd0);
        wait_done(20);

        // Back-to-back with request held high.
        i_wb_req = 1'b1; i_wb_addr = 32'hA000_0010;
        i_wb_data = {$urandom, $urandom, $urandom, $urandom};
        tick();
        i_wb_addr = 32'hB000_0020;
        i_wb_data = {$urandom, $urandom, $urandom, $urandom};
        wait_done(20);
        check_eq("t6_rdy_in_done", 32'(o_wb_rdy), 32'd1);
        tick();
        i_wb_req = 1'b0;
        check_eq("t6_aw_no_gap", 32'(o_awvalid), 32'd1);
        check_eq("t6_awaddr",    o_awaddr,       32'hB000_0020);
        wait_done(20);

        // Random traffic.
        last_addr = 32'h1C00_0040;
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            i_wb_req  = ($urandom_range(0, 2) == 0);
            i_wb_addr = $urandom;
            if (i_wb_req) last_addr = i_wb_addr;
            i_wb_data = {$urandom, $urandom, $urandom, $urandom};
            i_awready = $urandom_range(0, 1) == 1;
            i_wready  = $urandom_range(0, 1) == 1;
            i_bvalid  = $urandom_range(0, 1) == 1;
            i_chk_addr = ($urandom_range(0, 1) == 1)
                       ? {last_addr[31:4], 4'($urandom_range(0, 15))}
                       : $urandom;
            tick();
        end
        rst = 1'b0; i_wb_req = 1'b0;
        i_awready = 1'b1; i_wready = 1'b1; i_bvalid = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check_eq("final_idle", 32'(o_wb_rdy), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/write_back_buffer.md
Name: write_back_buffer

Overview:
- Transmit-side counterpart of the ICache/DCache line refill path.
- Accepts one dirty 128-bit cache line plus its address from the DCache.
- Serialises the line into a 4-beat, 32-bit AXI write burst (AW, W, B channels) toward the AXI bridge.
- Provides a line-address conflict check so the cache can stall a refill that would read stale memory.

Parameters:
AXI_ID, 4'd1, constant value driven on o_awid
LINE_BEATS, 4, beats per line; fixed at 4 (128/32); not meant to be overridden

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
i_wb_req  input  1  cache requests write-back; sampled only while o_wb_rdy=1
i_wb_addr  input  32  line address; bits [3:0] ignored, forced to 0 on o_awaddr
i_wb_data  input  128  line data; word 0 = [31:0]
o_wb_rdy  output  1  buffer idle, can accept a line
o_wb_done  output  1  one-cycle pulse when write response accepted
i_chk_addr  input  32  address the cache is about to refill
o_chk_hit  output  1  combinational; pending line matches i_chk_addr[31:4]
o_awvalid  output  1  AXI AW valid
i_awready  input  1  AXI AW ready
o_awaddr  output  32  {line_addr[31:4],4'b0}
o_awid  output  4  AXI_ID
o_awlen  output  8  constant 8'd3
o_awsize  output  3  constant 3'b010
o_awburst  output  2  constant 2'b01 (INCR)
o_wvalid  output  1  AXI W valid
i_wready  input  1  AXI W ready
o_wdata  output  32  current beat
o_wstrb  output  4  constant 4'hF
o_wlast  output  1  high on beat 3
i_bvalid  input  1  AXI B valid
o_bready  output  1  AXI B ready

Behaviour:
- State machine: IDLE, AW, W, B, held in a registered state field.
- Reset (rst=1 at a clock edge), from any state including mid-burst:
  - state=IDLE, beat counter=0.
  - o_awvalid, o_wvalid, o_wlast, o_bready, o_wb_done = 0.
  - Line address/data registers = 0.
  - o_wb_rdy=1 in the cycle after reset.
  - The interrupted burst is abandoned; no replay.
- IDLE:
  - o_wb_rdy=1.
  - On i_wb_req=1, latch {i_wb_addr[31:4],4'b0} and i_wb_data, then go to AW next cycle.
  - i_wb_req is ignored in every other state; o_wb_rdy=0 there.
- AW:
  - o_awvalid=1, held stable (address included) until i_awready=1 at a clock edge.
  - On that edge go to W with counter=0.
  - o_wvalid stays 0 in AW; no AW/W overlap.
- W:
  - o_wvalid=1; o_wdata = line[32*cnt+31 : 32*cnt], so word 0 goes first. This ordering makes a shift-in receiver rebuild the line in original order.
  - o_wlast = (cnt==3).
  - On i_wvalid&&i_wready (handshake) at an edge: cnt++. If cnt was 3, go to B and clear cnt.
  - Without i_wready, o_wdata and o_wlast stay stable and cnt holds.
- B:
  - o_bready=1.
  - On i_bvalid=1 at an edge: o_wb_done=1 for exactly the next cycle, state=IDLE, o_wb_rdy=1 in that same cycle.
  - Response code is not checked.
- Back-to-back: a new i_wb_req may be accepted in the cycle o_wb_done is high. Minimum IDLE-to-IDLE turnaround is 7 cycles with all readies high (accept, AW, 4×W, B).
- o_chk_hit:
  - = (state!=IDLE) && (i_chk_addr[31:4]==line_addr[31:4]).
  - Purely combinational and 0 in IDLE.
  - 0 in the cycle of acceptance, 1 from the next cycle until the return to IDLE.
- Constant AXI fields (o_awid, o_awlen, o_awsize, o_awburst, o_wstrb) are driven regardless of state.
- i_bvalid asserted outside state B, or i_wready asserted outside state W, has no effect.

Test Plan:
- Reset, then i_wb_req with addr 32'h1C00_0047, data 128'h4444_4444_3333_3333_2222_2222_1111_1111, all readies high → o_awaddr=32'h1C00_0040, then W beats 1111_1111, 2222_2222, 3333_3333, 4444_4444 with o_wlast only on the 4th beat, o_wb_done pulse exactly 7 cycles after the request edge.
- i_awready held low for 5 cycles → o_awvalid and o_awaddr stable throughout, o_wvalid=0; burst proceeds normally after i_awready rises.
- i_wready toggled 1,0,0,1,1,0,1 → exactly 4 handshakes; o_wdata/o_wlast unchanged during stalls; no beat skipped or duplicated.
- During burst to 32'h1C00_0040, i_chk_addr=32'h1C00_004C → o_chk_hit=1; i_chk_addr=32'h1C00_0050 → 0; after o_wb_done, same address → 0.
- rst pulsed in the cycle after beat 2 handshake → all valids 0 and o_wb_rdy=1 next cycle; next request restarts at beat 0 with new data.
- i_wb_req held high continuously with two different lines → second line accepted in the o_wb_done cycle, second AW follows with no idle gap; i_wb_req during B of the first line is ignored.
